alu_operand_seq: RTL

//  Upstream operand/command sequencer for the 4-bit board ALU. Captures A, B and the
//  3-bit op code from switches, one debounced button press per item, and drives the
//  ALU's a/b/ctrl inputs. Holds the operands stable while the result is shown on the

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_operand_seq_if.sv | 17 +
 rtl/alu_operand_seq_btn_debounce.sv | 51 +++++
 rtl/alu_operand_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encodings,
// ALU operand/op-code widths and the ALU op-code values.
package alu_seq_pkg;

  localparam int ALU_W   = 4;
  localparam int ALU_OPW = 3;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } seq_state_e;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OPW-1:0] OP_NOT = 3'd5;
  localparam logic [ALU_OPW-1:0] OP_LT  = 3'd6;
  localparam logic [ALU_OPW-1:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/alu_operand_seq_if.sv
// Command bus from the operand sequencer to the ALU: operands, op code and
// the valid level / start pulse that qualify them.
interface alu_operand_seq_if
  import alu_seq_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
);
  logic [W-1:0]   a_o;
  logic [W-1:0]   b_o;
  logic [OPW-1:0] ctrl_o;
  logic           op_valid;
  logic           op_start;

  modport master (output a_o, b_o, ctrl_o, op_valid, op_start);
  modport slave  (input  a_o, b_o, ctrl_o, op_valid, op_start);
endinterface

// File: rtl/alu_operand_seq_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stable-level debouncer and a
// one-cycle press pulse on each debounced 0->1 change.
module btn_debounce #(
  parameter int DEB_CNT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic          btn_s;

  assign btn_s = sync_q[1];
  assign press = press_q;

  // Any cycle agreeing with the debounced level restarts the window.
  always_comb begin
    sync_d  = {sync_q[0], btn};
    cnt_d   = cnt_q + CW'(1);
    deb_d   = deb_q;
    press_d = 1'b0;
    if (btn_s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      deb_d   = ~deb_q;
      press_d = ~deb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end
endmodule

// File: rtl/alu_operand_seq.sv
// Operand/command sequencer for the board ALU: one debounced press loads A, B,
// then the op code, and the command is held while the result is displayed.
//   state  | meaning
//   S_A    | waiting for press to load operand A
//   S_B    | waiting for press to load operand B
//   S_OP   | waiting for press to load op code and issue the command
//   S_SHOW | command valid and held; next press loads A of a new command
module alu_operand_seq
  import alu_seq_pkg::*;
#(
  parameter int W       = ALU_W,
  parameter int OPW     = ALU_OPW,
  parameter int DEB_CNT = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic               clr,
  input  logic [W-1:0]       sw_data,
  input  logic [OPW-1:0]     sw_op,
  alu_operand_seq_if.master  alu,
  output logic [1:0]         stage_o
);
  seq_state_e     state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [OPW-1:0] ctrl_q, ctrl_d;
  logic           valid_q, valid_d;
  logic           start_q, start_d;
  logic           press;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .press (press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    start_d = 1'b0;
    if (clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (press) begin
      unique case (state_q)
        S_A: begin
          a_d     = sw_data;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw_data;
          state_d = S_OP;
        end
        S_OP: begin
          ctrl_d  = sw_op;
          valid_d = 1'b1;
          start_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          valid_d = 1'b0;
          a_d     = sw_data;
          state_d = S_B;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end

  assign alu.a_o      = a_q;
  assign alu.b_o      = b_q;
  assign alu.ctrl_o   = ctrl_q;
  assign alu.op_valid = valid_q;
  assign alu.op_start = start_q;
  assign stage_o      = state_q;
endmodule
